acc_controller: RTL and testbench
=================================

// Module: acc_controller
// PURPOSE
//  Multi-cycle control FSM for the accumulator processor; drives every control input of the datapath
//  from opcode (IR[15:13]) and the accumulator zero flag. Moore machine: controls decode from
//  registered state only. One instruction runs 3-6 cycles; sits beside the datapath in the top level.
// PARAMETERS
//  OPC_W    3  opcode width
//  ALUOP_W  2  ALU operation select width
//  ST_W     4  state register width (11 states)
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        asynchronous, active-high reset
//  opcode        in   OPC_W    IR[15:13] from datapath
//  zero          in   1        ACC == 0 flag from datapath
//  PC_init       out  1        force PC to 0
//  PCwrite       out  1        unconditional PC load
//  PCwrite_cond  out  1        PC load if zero
//  PCsrc         out  1        0: ALU result, 1: IR[12:0]
//  IorD          out  1        memory address: 0 PC, 1 IR[12:0]
//  MemRead       out  1        memory read enable
//  MemWrite      out  1        memory write enable (data = ACC)
//  IRwrite       out  1        IR load
//  ldACC         out  1        ACC load
//  ACCsrc        out  1        ACC input: 0 ALU reg, 1 MDR
//  ldA, ldB      out  1 each   operand register loads
//  Asrc          out  1        ALU A: 0 A reg, 1 PC
//  Bsrc          out  1        ALU B: 0 B reg, 1 const 1
//  ALUop         out  ALUOP_W  00 ADD, 01 SUB, 10 AND, 11 NOT (NOT complements B)
//  state         out  ST_W     current state (debug)
//  instr_done    out  1        1-cycle pulse in the last state of each instruction
// BEHAVIOUR
//  ISA: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 LDA, 101 STA, 110 JMP, 111 JZ; operand addr = IR[12:0].
//  Reset: state <= INIT asynchronously; in INIT only PC_init=1, every other output 0.
//  Unlisted controls are 0 in every state; ALUop defaults to 00.
//  INIT:    PC_init=1                                      -> FETCH
//  FETCH:   IorD=0 MemRead IRwrite Asrc=1 Bsrc=1 ALUop=00 PCsrc=0 PCwrite   -> DECODE
//  DECODE:  no controls. JMP->JUMP; JZ->BRZ; STA->STORE; NOT->OPLOAD; else->MEM_RD
//  MEM_RD:  IorD=1 MemRead. LDA->LOAD_WB; else->OPLOAD
//  OPLOAD:  ldA ldB                                        -> EXEC
//  EXEC:    Asrc=0 Bsrc=0 ALUop=opcode[1:0] (ALU reg latches at edge)   -> ALU_WB
//  ALU_WB:  ldACC ACCsrc=0 instr_done                      -> FETCH
//  LOAD_WB: ldACC ACCsrc=1 instr_done                      -> FETCH
//  STORE:   IorD=1 MemWrite instr_done                     -> FETCH
//  JUMP:    PCsrc=1 PCwrite instr_done                     -> FETCH
//  BRZ:     PCsrc=1 PCwrite_cond instr_done                -> FETCH (PC update gated by datapath on zero)
//  Latency (FETCH..last state inclusive): ADD/SUB/AND 6, NOT 5, LDA 4, STA/JMP/JZ 3.
//  opcode is decoded only in DECODE..EXEC; IR is stable there since IRwrite is asserted only in FETCH.
//  zero is not sampled by the FSM; it passes straight to the datapath PC logic (no next-state effect).
//  Mutual exclusion: MemRead & MemWrite never both 1; PCwrite & PCwrite_cond never both 1.
//  Unused state encodings -> INIT on the next edge, with INIT outputs.
//  rst mid-instruction: abort immediately, no further write strobes, restart at INIT.
// STRUCTURE
//  acc_isa_pkg: opcode localparams, ALUop codes, state encodings; the datapath bench shares it.
//  One sub-module, acc_ctrl_outdec: combinational state/opcode -> control-vector decoder.
//  Top keeps the state register and next-state logic only.
// TESTING
//  rst=1 then release -> INIT 1 cycle (PC_init=1, all else 0), then FETCH with MemRead/IRwrite/PCwrite.
//  opcode=000 -> FETCH,DECODE,MEM_RD,OPLOAD,EXEC(ALUop=00),ALU_WB(ldACC,ACCsrc=0); done on cycle 6.
//  opcode=100 -> FETCH,DECODE,MEM_RD,LOAD_WB(ACCsrc=1); opcode=011 skips MEM_RD, EXEC ALUop=11.
//  opcode=101 -> STORE with IorD=1 MemWrite=1 MemRead=0; opcode=110 -> JUMP PCsrc=1 PCwrite=1.
//  opcode=111 with zero=0 and zero=1 -> BRZ both times, PCwrite_cond=1, PCwrite=0, 3 cycles.
//  rst pulsed during EXEC and during STORE -> outputs go to INIT values asynchronously; no ldACC/MemWrite.

Source files
------------

// File: rtl/acc_isa_pkg.sv
// Shared ISA definitions for the accumulator processor: opcodes, ALU op codes and
// controller state encodings (also used by the datapath bench).
package acc_isa_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_LDA = 3'b100;
  localparam logic [2:0] OP_STA = 3'b101;
  localparam logic [2:0] OP_JMP = 3'b110;
  localparam logic [2:0] OP_JZ  = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEM_RD  = 4'd3,
    S_OPLOAD  = 4'd4,
    S_EXEC    = 4'd5,
    S_ALU_WB  = 4'd6,
    S_LOAD_WB = 4'd7,
    S_STORE   = 4'd8,
    S_JUMP    = 4'd9,
    S_BRZ     = 4'd10
  } state_t;

endpackage

// File: rtl/acc_ctrl_outdec.sv
// Moore control decoder: registered state (plus stable IR opcode in EXEC) -> datapath controls.
module acc_ctrl_outdec
  import acc_isa_pkg::*;
#(
  parameter int OPC_W   = 3,
  parameter int ALUOP_W = 2,
  parameter int ST_W    = 4
) (
  input  logic [ST_W-1:0]    state_i,
  input  logic [OPC_W-1:0]   opcode_i,
  output logic               PC_init_o,
  output logic               PCwrite_o,
  output logic               PCwrite_cond_o,
  output logic               PCsrc_o,
  output logic               IorD_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               IRwrite_o,
  output logic               ldACC_o,
  output logic               ACCsrc_o,
  output logic               ldA_o,
  output logic               ldB_o,
  output logic               Asrc_o,
  output logic               Bsrc_o,
  output logic [ALUOP_W-1:0] ALUop_o,
  output logic               instr_done_o
);

  state_t st;
  assign st = state_t'(state_i);

  always_comb begin
    PC_init_o      = 1'b0;
    PCwrite_o      = 1'b0;
    PCwrite_cond_o = 1'b0;
    PCsrc_o        = 1'b0;
    IorD_o         = 1'b0;
    MemRead_o      = 1'b0;
    MemWrite_o     = 1'b0;
    IRwrite_o      = 1'b0;
    ldACC_o        = 1'b0;
    ACCsrc_o       = 1'b0;
    ldA_o          = 1'b0;
    ldB_o          = 1'b0;
    Asrc_o         = 1'b0;
    Bsrc_o         = 1'b0;
    ALUop_o        = '0;
    instr_done_o   = 1'b0;
    case (st)
      S_INIT:   PC_init_o = 1'b1;
      S_FETCH: begin
        // ALU computes PC+1 while memory returns the instruction
        MemRead_o = 1'b1;
        IRwrite_o = 1'b1;
        Asrc_o    = 1'b1;
        Bsrc_o    = 1'b1;
        PCwrite_o = 1'b1;
      end
      S_DECODE: ;
      S_MEM_RD: begin
        IorD_o    = 1'b1;
        MemRead_o = 1'b1;
      end
      S_OPLOAD: begin
        ldA_o = 1'b1;
        ldB_o = 1'b1;
      end
      S_EXEC:   ALUop_o = opcode_i[ALUOP_W-1:0];
      S_ALU_WB: begin
        ldACC_o      = 1'b1;
        instr_done_o = 1'b1;
      end
      S_LOAD_WB: begin
        ldACC_o      = 1'b1;
        ACCsrc_o     = 1'b1;
        instr_done_o = 1'b1;
      end
      S_STORE: begin
        IorD_o       = 1'b1;
        MemWrite_o   = 1'b1;
        instr_done_o = 1'b1;
      end
      S_JUMP: begin
        PCsrc_o      = 1'b1;
        PCwrite_o    = 1'b1;
        instr_done_o = 1'b1;
      end
      S_BRZ: begin
        PCsrc_o        = 1'b1;
        PCwrite_cond_o = 1'b1;
        instr_done_o   = 1'b1;
      end
      // unused encodings look like INIT until the next edge recovers
      default:  PC_init_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/acc_controller.sv
// Multi-cycle control FSM for the accumulator processor: state register and
// next-state logic; control outputs come from acc_ctrl_outdec.
module acc_controller
  import acc_isa_pkg::*;
#(
  parameter int OPC_W   = 3,
  parameter int ALUOP_W = 2,
  parameter int ST_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  output logic               PC_init,
  output logic               PCwrite,
  output logic               PCwrite_cond,
  output logic               PCsrc,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRwrite,
  output logic               ldACC,
  output logic               ACCsrc,
  output logic               ldA,
  output logic               ldB,
  output logic               Asrc,
  output logic               Bsrc,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [ST_W-1:0]    state,
  output logic               instr_done
);

  state_t state_q, state_d;

  // zero feeds the datapath PC logic directly; the FSM never branches on it
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_INIT;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_JMP:  state_d = S_JUMP;
          OP_JZ:   state_d = S_BRZ;
          OP_STA:  state_d = S_STORE;
          OP_NOT:  state_d = S_OPLOAD;
          default: state_d = S_MEM_RD;
        endcase
      end
      S_MEM_RD: state_d = (opcode == OP_LDA) ? S_LOAD_WB : S_OPLOAD;
      S_OPLOAD: state_d = S_EXEC;
      S_EXEC:   state_d = S_ALU_WB;
      S_ALU_WB, S_LOAD_WB, S_STORE, S_JUMP, S_BRZ: state_d = S_FETCH;
      default:  state_d = S_INIT;
    endcase
  end

  assign state = ST_W'(state_q);

  acc_ctrl_outdec #(
    .OPC_W  (OPC_W),
    .ALUOP_W(ALUOP_W),
    .ST_W   (ST_W)
  ) u_outdec (
    .state_i       (state),
    .opcode_i      (opcode),
    .PC_init_o     (PC_init),
    .PCwrite_o     (PCwrite),
    .PCwrite_cond_o(PCwrite_cond),
    .PCsrc_o       (PCsrc),
    .IorD_o        (IorD),
    .MemRead_o     (MemRead),
    .MemWrite_o    (MemWrite),
    .IRwrite_o     (IRwrite),
    .ldACC_o       (ldACC),
    .ACCsrc_o      (ACCsrc),
    .ldA_o         (ldA),
    .ldB_o         (ldB),
    .Asrc_o        (Asrc),
    .Bsrc_o        (Bsrc),
    .ALUop_o       (ALUop),
    .instr_done_o  (instr_done)
  );

endmodule

// File: tb/tb_acc_controller.sv
// Scoreboard bench for acc_controller: stimulus pushes one expected control vector per
// cycle from an instruction-level phase model; a negedge monitor pops and compares.
module tb_acc_controller;
  import acc_isa_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       PC_init, PCwrite, PCwrite_cond, PCsrc, IorD, MemRead, MemWrite, IRwrite;
  logic       ldACC, ACCsrc, ldA, ldB, Asrc, Bsrc, instr_done;
  logic [1:0] ALUop;
  logic [3:0] state;

  acc_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .PC_init(PC_init), .PCwrite(PCwrite), .PCwrite_cond(PCwrite_cond), .PCsrc(PCsrc),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRwrite(IRwrite),
    .ldACC(ldACC), .ACCsrc(ACCsrc), .ldA(ldA), .ldB(ldB), .Asrc(Asrc), .Bsrc(Bsrc),
    .ALUop(ALUop), .state(state), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       PC_init, PCwrite, PCwrite_cond, PCsrc, IorD, MemRead, MemWrite, IRwrite;
    logic       ldACC, ACCsrc, ldA, ldB, Asrc, Bsrc;
    logic [1:0] ALUop;
    logic       instr_done;
    logic [3:0] st;
  } vec_t;

  vec_t   exp_q[$];
  state_t seq_q[$];
  int     n_chk  = 0;
  int     n_fail = 0;
  int     cyc    = 0;

  // Control set asserted in each phase, straight from the instruction phase table.
  function automatic vec_t expect_of(state_t s, logic [2:0] op);
    vec_t v = '0;
    v.st = s;
    case (s)
      S_INIT:    v.PC_init = 1'b1;
      S_FETCH:   begin v.MemRead = 1; v.IRwrite = 1; v.Asrc = 1; v.Bsrc = 1; v.PCwrite = 1; end
      S_MEM_RD:  begin v.IorD = 1; v.MemRead = 1; end
      S_OPLOAD:  begin v.ldA = 1; v.ldB = 1; end
      S_EXEC:    v.ALUop = op[1:0];
      S_ALU_WB:  begin v.ldACC = 1; v.instr_done = 1; end
      S_LOAD_WB: begin v.ldACC = 1; v.ACCsrc = 1; v.instr_done = 1; end
      S_STORE:   begin v.IorD = 1; v.MemWrite = 1; v.instr_done = 1; end
      S_JUMP:    begin v.PCsrc = 1; v.PCwrite = 1; v.instr_done = 1; end
      S_BRZ:     begin v.PCsrc = 1; v.PCwrite_cond = 1; v.instr_done = 1; end
      default:   ;
    endcase
    return v;
  endfunction

  task automatic build_seq(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND: seq_q = '{S_FETCH, S_DECODE, S_MEM_RD, S_OPLOAD, S_EXEC, S_ALU_WB};
      OP_NOT: seq_q = '{S_FETCH, S_DECODE, S_OPLOAD, S_EXEC, S_ALU_WB};
      OP_LDA: seq_q = '{S_FETCH, S_DECODE, S_MEM_RD, S_LOAD_WB};
      OP_STA: seq_q = '{S_FETCH, S_DECODE, S_STORE};
      OP_JMP: seq_q = '{S_FETCH, S_DECODE, S_JUMP};
      default: seq_q = '{S_FETCH, S_DECODE, S_BRZ};
    endcase
  endtask

  // Holds rst for n cycles then releases it; INIT is expected throughout and for one cycle after.
  task automatic reset_seq(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.push_back(expect_of(S_INIT, 3'b000));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(expect_of(S_INIT, 3'b000));
  endtask

  // zval < 0 randomises zero each cycle; abort_at >= 0 pulses rst in that phase.
  task automatic run_instr(input logic [2:0] op, input int zval, input int abort_at);
    build_seq(op);
    for (int i = 0; i < seq_q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) opcode = op;
      zero = (zval < 0) ? 1'($urandom_range(0, 1)) : 1'(zval);
      if (i == abort_at) begin
        #2 rst = 1'b1;
        exp_q.push_back(expect_of(S_INIT, op));
        reset_seq(1);
        return;
      end
      exp_q.push_back(expect_of(seq_q[i], op));
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      vec_t e, a;
      e = exp_q.pop_front();
      a = '{PC_init, PCwrite, PCwrite_cond, PCsrc, IorD, MemRead, MemWrite, IRwrite,
            ldACC, ACCsrc, ldA, ldB, Asrc, Bsrc, ALUop, instr_done, state};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ctrl_vec cyc=%0d got=%h want=%h (state got %0d want %0d)",
                 cyc, a, e, a.st, e.st);
      end
      n_chk++;
      if ((MemRead & MemWrite) | (PCwrite & PCwrite_cond)) begin
        n_fail++;
        $display("FAIL mutex cyc=%0d MemRead=%b MemWrite=%b PCwrite=%b PCwrite_cond=%b",
                 cyc, MemRead, MemWrite, PCwrite, PCwrite_cond);
      end
    end
  end

  initial begin
    reset_seq(2);
    run_instr(OP_ADD, -1, -1);
    run_instr(OP_LDA, -1, -1);
    run_instr(OP_NOT, -1, -1);
    run_instr(OP_STA, -1, -1);
    run_instr(OP_JMP, -1, -1);
    run_instr(OP_JZ,   0, -1);
    run_instr(OP_JZ,   1, -1);
    run_instr(OP_SUB, -1, -1);
    run_instr(OP_AND, -1, -1);
    run_instr(OP_ADD, -1, 4);   // abort in EXEC
    run_instr(OP_STA, -1, 2);   // abort in STORE
    for (int k = 0; k < 60; k++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      if (k % 17 == 16) begin
        build_seq(op);
        run_instr(op, -1, int'($urandom_range(0, seq_q.size() - 1)));
      end else begin
        run_instr(op, -1, -1);
      end
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
